// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32I core.
// Owns the program counter, drives the instruction-memory address and registers the returned
// word into the IF/ID pipeline register together with its PC, PC+4 and a valid bit.
//
// Build option: define FETCH_STATIC_PREDICT_EN to enable the static predictor. It steers fetch
// to backward conditional branches and to JAL targets. Without the macro the next PC is only
// reset / redirect / hold / pc+4 and pred_taken_d is tied low.

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        pred_taken_d
);

    localparam logic [31:0] ResetPcPlus4 = RESET_PC + 32'd4;
    localparam logic [6:0]  OpBranch     = 7'b1100011;
    localparam logic [6:0]  OpJal        = 7'b1101111;

    // Fetch-side state and next-state.
    logic [31:0] pc_f_q;
    logic [31:0] pc_f_next;
    logic [31:0] pc_plus4_f;
    logic [31:0] redirect_target;
    logic        pred_taken_f;

    // IF/ID register and its next-state.
    logic [31:0] instr_q,    instr_next;
    logic [31:0] pc_q,       pc_next;
    logic [31:0] pc_plus4_q, pc_plus4_next;
    logic        valid_q,    valid_next;
    logic        pred_q,     pred_next;

    // Targets are word aligned; the low two bits of a redirect are dropped.
    logic [1:0] unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc_e[1:0];

    assign imem_addr       = pc_f_q;
    assign pc_plus4_f      = pc_f_q + 32'd4;
    assign redirect_target = {redirect_pc_e[31:2], 2'b00};

`ifdef FETCH_STATIC_PREDICT_EN
    logic [6:0]  opcode_f;
    logic        is_branch_f;
    logic        is_jal_f;
    logic [31:0] imm_b_f;
    logic [31:0] imm_j_f;
    logic [31:0] pred_target_f;

    assign opcode_f    = imem_rd[6:0];
    assign is_branch_f = (opcode_f == OpBranch);
    assign is_jal_f    = (opcode_f == OpJal);

    assign imm_b_f = {{20{imem_rd[31]}}, imem_rd[7], imem_rd[30:25], imem_rd[11:8], 1'b0};
    assign imm_j_f = {{12{imem_rd[31]}}, imem_rd[19:12], imem_rd[20], imem_rd[30:21], 1'b0};

    // Backward branches (negative offset) and JAL are predicted taken; JALR never is.
    // A stalled or redirected fetch is not a real fetch, so its prediction is suppressed.
    always_comb begin
        pred_taken_f  = 1'b0;
        pred_target_f = pc_plus4_f;
        if (is_jal_f) begin
            pred_taken_f  = 1'b1;
            pred_target_f = pc_f_q + imm_j_f;
        end else if (is_branch_f && imem_rd[31]) begin
            pred_taken_f  = 1'b1;
            pred_target_f = pc_f_q + imm_b_f;
        end
        if (stall_f || redirect_e) begin
            pred_taken_f = 1'b0;
        end
    end
`else
    assign pred_taken_f = 1'b0;
`endif

    // Next PC: redirect beats stall, stall beats prediction, prediction beats sequential.
    always_comb begin
        pc_f_next = pc_plus4_f;
        if (redirect_e) begin
            pc_f_next = redirect_target;
        end else if (stall_f) begin
            pc_f_next = pc_f_q;
`ifdef FETCH_STATIC_PREDICT_EN
        end else if (pred_taken_f) begin
            pc_f_next = pred_target_f;
`endif
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_next;
        end
    end

    // IF/ID next-state: flush/redirect bubble, then hold on stall_d, then bubble on a
    // fetch-only stall so the held instruction is not issued twice, otherwise load.
    always_comb begin
        instr_next    = instr_q;
        pc_next       = pc_q;
        pc_plus4_next = pc_plus4_q;
        valid_next    = valid_q;
        pred_next     = pred_q;
        if (flush_d || redirect_e || (stall_f && !stall_d)) begin
            instr_next    = NOP_INSTR;
            pc_next       = RESET_PC;
            pc_plus4_next = ResetPcPlus4;
            valid_next    = 1'b0;
            pred_next     = 1'b0;
        end else if (!stall_d) begin
            instr_next    = imem_rd;
            pc_next       = pc_f_q;
            pc_plus4_next = pc_plus4_f;
            valid_next    = 1'b1;
            pred_next     = pred_taken_f;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            pc_plus4_q <= ResetPcPlus4;
            valid_q    <= 1'b0;
            pred_q     <= 1'b0;
        end else begin
            instr_q    <= instr_next;
            pc_q       <= pc_next;
            pc_plus4_q <= pc_plus4_next;
            valid_q    <= valid_next;
            pred_q     <= pred_next;
        end
    end

    assign instr_d      = instr_q;
    assign pc_d         = pc_q;
    assign pc_plus4_d   = pc_plus4_q;
    assign valid_d      = valid_q;
    assign pred_taken_d = pred_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Instruction memory is a combinational model:
// every word is a distinct addi-class encoding derived from its address, except a backward
// beq (0xFE000EE3) planted at 0xBFC00010.

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        pred_taken_d;

    int checks;
    int failures;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] RPC  = 32'hBFC00000;
    localparam logic [31:0] BEQ  = 32'hFE000EE3;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .redirect_e   (redirect_e),
        .redirect_pc_e(redirect_pc_e),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .pred_taken_d (pred_taken_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00010) return BEQ;
        return {a[26:2], 7'h13};
    endfunction

    assign imem_rd = mem_word(imem_addr);

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        redirect_e    = 1'b0;
        redirect_pc_e = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (imem_addr !== RPC) begin failures++;
            $display("FAIL reset_pc actual=%h expected=%h", imem_addr, RPC); end
        checks++; if (instr_d !== NOP) begin failures++;
            $display("FAIL reset_instr actual=%h expected=%h", instr_d, NOP); end
        checks++; if (pc_d !== RPC || pc_plus4_d !== 32'hBFC00004) begin failures++;
            $display("FAIL reset_pcd actual=%h/%h expected=%h/%h", pc_d, pc_plus4_d,
                     RPC, 32'hBFC00004); end
        checks++; if (valid_d !== 1'b0 || pred_taken_d !== 1'b0) begin failures++;
            $display("FAIL reset_valid actual=%b/%b expected=0/0", valid_d, pred_taken_d); end
        rst = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'hBFC00004) begin failures++;
            $display("FAIL first_pc actual=%h expected=%h", imem_addr, 32'hBFC00004); end
        checks++; if (valid_d !== 1'b1 || pc_d !== RPC || instr_d !== mem_word(RPC)
                      || pc_plus4_d !== 32'hBFC00004) begin failures++;
            $display("FAIL first_ifid actual=%b %h %h %h expected=1 %h %h %h", valid_d, pc_d,
                     instr_d, pc_plus4_d, RPC, mem_word(RPC), 32'hBFC00004); end
        tick();
        checks++; if (imem_addr !== 32'hBFC00008 || pc_d !== 32'hBFC00004) begin failures++;
            $display("FAIL second_fetch actual=%h/%h expected=%h/%h", imem_addr, pc_d,
                     32'hBFC00008, 32'hBFC00004); end
    endtask

    task automatic test_stall();
        stall_f = 1'b1;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 32'hBFC00008 || pc_d !== 32'hBFC00004 ||
                          valid_d !== 1'b1 || instr_d !== mem_word(32'hBFC00004)) begin
                failures++;
                $display("FAIL stall_hold[%0d] actual=%h %h %b %h expected=%h %h 1 %h", i,
                         imem_addr, pc_d, valid_d, instr_d, 32'hBFC00008, 32'hBFC00004,
                         mem_word(32'hBFC00004));
            end
        end
        stall_d = 1'b0;
        tick();
        checks++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== RPC ||
                      imem_addr !== 32'hBFC00008) begin failures++;
            $display("FAIL stall_bubble actual=%b %h %h %h expected=0 %h %h %h", valid_d,
                     instr_d, pc_d, imem_addr, NOP, RPC, 32'hBFC00008); end
        stall_f = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'hBFC0000C || pc_d !== 32'hBFC00008 ||
                      valid_d !== 1'b1) begin failures++;
            $display("FAIL stall_release actual=%h %h %b expected=%h %h 1", imem_addr, pc_d,
                     valid_d, 32'hBFC0000C, 32'hBFC00008); end
    endtask

    task automatic test_redirect();
        redirect_e    = 1'b1;
        redirect_pc_e = 32'hBFC00103;
        stall_f       = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'hBFC00100 || valid_d !== 1'b0) begin failures++;
            $display("FAIL redirect_pc actual=%h %b expected=%h 0", imem_addr, valid_d,
                     32'hBFC00100); end
        clear_inputs();
        tick();
        checks++; if (pc_d !== 32'hBFC00100 || instr_d !== mem_word(32'hBFC00100) ||
                      valid_d !== 1'b1 || imem_addr !== 32'hBFC00104) begin failures++;
            $display("FAIL redirect_target actual=%h %h %b %h expected=%h %h 1 %h", pc_d,
                     instr_d, valid_d, imem_addr, 32'hBFC00100, mem_word(32'hBFC00100),
                     32'hBFC00104); end
    endtask

    task automatic test_flush_vs_stall();
        flush_d = 1'b1;
        stall_d = 1'b1;
        tick();
        checks++; if (valid_d !== 1'b0 || instr_d !== NOP || pc_plus4_d !== 32'hBFC00004)
        begin failures++;
            $display("FAIL flush_stall actual=%b %h %h expected=0 %h %h", valid_d, instr_d,
                     pc_plus4_d, NOP, 32'hBFC00004); end
        checks++; if (imem_addr !== 32'hBFC00108) begin failures++;
            $display("FAIL flush_pc actual=%h expected=%h", imem_addr, 32'hBFC00108); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        redirect_e    = 1'b1;
        redirect_pc_e = 32'hFFFFFFFC;
        tick();
        checks++; if (imem_addr !== 32'hFFFFFFFC) begin failures++;
            $display("FAIL wrap_redirect actual=%h expected=%h", imem_addr, 32'hFFFFFFFC); end
        clear_inputs();
        tick();
        checks++; if (imem_addr !== 32'h0 || pc_d !== 32'hFFFFFFFC || pc_plus4_d !== 32'h0 ||
                      valid_d !== 1'b1) begin failures++;
            $display("FAIL wrap_next actual=%h %h %h %b expected=0 fffffffc 0 1", imem_addr,
                     pc_d, pc_plus4_d, valid_d); end
    endtask

    task automatic test_predict();
        logic [31:0] exp_pc;
        logic        exp_pred;
`ifdef FETCH_STATIC_PREDICT_EN
        exp_pc   = 32'hBFC0000C;
        exp_pred = 1'b1;
`else
        exp_pc   = 32'hBFC00014;
        exp_pred = 1'b0;
`endif
        redirect_e    = 1'b1;
        redirect_pc_e = 32'hBFC00010;
        tick();
        clear_inputs();
        // Stalled fetch of the branch must not steer the PC.
        stall_f = 1'b1;
        stall_d = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'hBFC00010) begin failures++;
            $display("FAIL predict_stalled actual=%h expected=%h", imem_addr, 32'hBFC00010); end
        clear_inputs();
        tick();
        checks++; if (imem_addr !== exp_pc || pred_taken_d !== exp_pred) begin failures++;
            $display("FAIL predict_branch actual=%h %b expected=%h %b", imem_addr,
                     pred_taken_d, exp_pc, exp_pred); end
        checks++; if (pc_d !== 32'hBFC00010 || instr_d !== BEQ || valid_d !== 1'b1) begin
            failures++;
            $display("FAIL predict_ifid actual=%h %h %b expected=%h %h 1", pc_d, instr_d,
                     valid_d, 32'hBFC00010, BEQ); end
    endtask

    task automatic test_reset_mid();
        redirect_e    = 1'b1;
        redirect_pc_e = 32'h00001000;
        stall_d       = 1'b1;
        rst           = 1'b1;
        tick();
        checks++; if (imem_addr !== RPC || valid_d !== 1'b0 || instr_d !== NOP) begin
            failures++;
            $display("FAIL reset_mid actual=%h %b %h expected=%h 0 %h", imem_addr, valid_d,
                     instr_d, RPC, NOP); end
        clear_inputs();
        rst = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'hBFC00004 || pc_d !== RPC || valid_d !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_release actual=%h %h %b expected=%h %h 1", imem_addr,
                     pc_d, valid_d, 32'hBFC00004, RPC); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_stall();
        test_redirect();
        test_flush_vs_stall();
        test_wrap();
        test_predict();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the program counter, drives the instruction-memory address, and registers the returned word into the IF/ID pipeline register with its PC, PC+4 and a valid bit. It accepts stall/flush controls from the hazard unit and a redirect from execute. An optional static predictor steers fetch to backward branches and JAL targets.

## Interface
- RESET_PC, 32'hBFC00000, PC loaded on reset; base of instruction ROM
- NOP_INSTR, 32'h00000013, word placed in instr_d for bubbles (addi x0,x0,0)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  insert bubble into IF/ID
- redirect_e  in  1  execute-stage redirect (taken branch/jump, or mispredict recovery)
- redirect_pc_e  in  32  redirect target
- imem_addr  out  32  byte address to instruction memory; equals pc_f
- imem_rd  in  32  instruction word from memory, combinational from imem_addr
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- pred_taken_d  out  1  fetch predicted this instruction taken

## Operation
- State: pc_f (32), IF/ID register {instr_d, pc_d, pc_plus4_d, valid_d, pred_taken_d}.
- imem_addr = pc_f, combinational.
- Next pc_f priority: rst -> RESET_PC; redirect_e -> {redirect_pc_e[31:2],2'b00}; stall_f -> hold; prediction taken -> pc_f + imm; else pc_f + 4.
- Arithmetic is 32-bit modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0. No range check against the ROM window.
- IF/ID priority: rst -> bubble; flush_d or redirect_e -> bubble; stall_d -> hold all fields; stall_f && !stall_d -> bubble (prevents duplicate issue); else load {imem_rd, pc_f, pc_f+4, 1, pred}.
- Bubble = instr_d NOP_INSTR, pc_d RESET_PC, pc_plus4_d RESET_PC+4, valid_d 0, pred_taken_d 0.
- redirect_e overrides stall_f and stall_d.
- Predictor (macro only): decodes imem_rd in fetch.
  - B-type (opcode 7'b1100011) with imem_rd[31]=1: taken, imm = sext{i[31],i[7],i[30:25],i[11:8],0}.
  - JAL (7'b1101111): taken, imm = sext{i[31],i[19:12],i[20],i[30:21],0}.
  - Otherwise not taken. JALR is never predicted.
  - Prediction is suppressed (pred=0, next = pc+4 rule not applied) when stall_f or redirect_e.
- Execute compares its outcome with pred_taken_d and issues redirect_e on mismatch (redirect_pc_e = pc+4 for a wrongly taken prediction).

## Timing
- Reset values: pc_f = imem_addr = RESET_PC; instr_d = NOP_INSTR; pc_d = RESET_PC; pc_plus4_d = RESET_PC+4; valid_d = 0; pred_taken_d = 0.
- First edge after rst falls: IF/ID holds word at RESET_PC, valid_d = 1.
- Fetch-to-decode latency: 1 cycle.
- Redirect in cycle n: cycle n+1 pc_f = target, valid_d = 0; cycle n+2 target instruction in IF/ID.
- Predicted-taken fetch in cycle n: cycle n+1 pc_f = target, IF/ID holds the branch with pred_taken_d = 1; zero bubbles.
- rst asserted mid-operation wins over all inputs on that edge.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: predictor as above, pred_taken_d reflects prediction.
- Undefined: next PC is only reset/redirect/hold/pc+4; pred_taken_d tied 0; no decode logic instantiated.

## Test plan
- Reset: hold rst 2 cycles, release -> imem_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive cycles; valid_d 0 then 1 with pc_d 0xBFC00000.
- Stall: stall_f=stall_d=1 for 3 cycles at pc 0xBFC00008 -> imem_addr and IF/ID unchanged; stall_f=1, stall_d=0 -> valid_d 0, instr_d 0x00000013.
- Redirect: redirect_e=1, redirect_pc_e=0xBFC00103 with stall_f=1 -> next pc_f 0xBFC00100, valid_d 0 next cycle, instr at 0xBFC00100 in IF/ID the cycle after.
- Flush vs stall: flush_d=1, stall_d=1 -> bubble loaded, valid_d 0.
- Wrap: redirect to 0xFFFFFFFC, no stall -> next imem_addr 0x00000000.
- Predictor (macro on): word 0xFE000EE3 (beq x0,x0,-4) at 0xBFC00010 -> next pc_f 0xBFC0000C, pred_taken_d 1; macro off -> 0xBFC00014, pred_taken_d 0.
